// File: rtl/sync_up_jk_if.sv
// sync_up_jk_if: control/status bundle for the sync_up_jk counter.
//   master modport (sequencer side): drives en, load, clr, din; observes q, tc, wrap,
//                                    j_dbg, k_dbg.
//   slave modport  (counter side)  : the reverse.
// Signals:
//   en    - count enable
//   load  - synchronous load strobe, din is the load value
//   clr   - synchronous clear
//   q     - registered count
//   tc    - terminal count (combinational)
//   wrap  - registered one-cycle wrap pulse
//   j_dbg - per-bit J excitation applied at the current edge
//   k_dbg - per-bit K excitation applied at the current edge
interface sync_up_jk_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             load;
    logic             clr;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] q;
    logic             tc;
    logic             wrap;
    logic [WIDTH-1:0] j_dbg;
    logic [WIDTH-1:0] k_dbg;

    modport master (
        output en, load, clr, din,
        input  q, tc, wrap, j_dbg, k_dbg
    );

    modport slave (
        input  en, load, clr, din,
        output q, tc, wrap, j_dbg, k_dbg
    );
endinterface

// File: rtl/sync_up_jk.sv
// sync_up_jk: synchronous modulo-MOD up counter whose state bits are JK flip-flop cells.
// Each bit is updated only through J/K excitation and the JK characteristic equation.
// Parameters: WIDTH (2..16) is the counter width; the modulus (2..2^WIDTH) sets the
// count range 0..MOD-1.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset (q=0, wrap=0, tc=0 while low)
//   bus   - sync_up_jk_if.slave: en/load/clr/din in; q/tc/wrap/j_dbg/k_dbg out
// Build option:
//   SYNC_UP_JK_SAT_EN - when defined the counter saturates at MOD-1 instead of wrapping,
//                       and wrap is never asserted.
module sync_up_jk #(
    parameter int WIDTH = 4,
    parameter int MOD   = 10
) (
    input  logic         clk,
    input  logic         reset,
    sync_up_jk_if.slave  bus
);
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] LAST    = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] q_next;
    logic             wrap_r;
    logic             wrap_set;
    logic             at_last;

    // Target value selection, then JK excitation toward it.
    always_comb begin
        at_last  = (q_r == LAST);
        n        = q_r;
        wrap_set = 1'b0;
        if (bus.clr) begin
            n = '0;
        end else if (bus.load) begin
            // Out-of-range load values clamp to zero.
            n = ({1'b0, bus.din} >= MOD_EXT) ? '0 : bus.din;
        end else if (bus.en) begin
            if ({1'b0, q_r} >= MOD_EXT) begin
                // Illegal state recovery: back to zero without a wrap pulse.
                n = '0;
            end else if (at_last) begin
`ifdef SYNC_UP_JK_SAT_EN
                n = q_r;
`else
                n        = '0;
                wrap_set = 1'b1;
`endif
            end else begin
                n = q_r + WIDTH'(1);
            end
        end
        j      = ~q_r & n;
        k      = q_r & ~n;
        q_next = (j & ~q_r) | (~k & q_r);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next;
            wrap_r <= wrap_set;
        end
    end

    assign bus.q     = q_r;
    assign bus.wrap  = wrap_r;
    assign bus.tc    = reset & at_last & bus.en;
    assign bus.j_dbg = j;
    assign bus.k_dbg = k;
endmodule

// File: doc/sync_up_jk.md
Name: sync_up_jk

Overview:
- Synchronous N-bit up counter built from JK flip-flop cells, with a programmable modulus.
- It is the count-up counterpart of the team's synchronous down counters built from JK cells.
- Every bit's next state is produced through JK excitation (J/K per bit, then the JK characteristic equation), never by direct adder assignment.
- Used as a cycle/event counter that feeds terminal-count pulses to downstream sequencers.

Parameters:
- WIDTH, 4, counter width in bits (legal range 2..16).
- MOD, 10, count modulus (legal range 2..2^WIDTH); the counter runs 0..MOD-1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
- en  input  1  count enable; counter advances by 1 on a clk edge when en=1.
- load  input  1  synchronous load strobe.
- din  input  WIDTH  load value.
- clr  input  1  synchronous clear to 0.
- q  output  WIDTH  current count (registered).
- tc  output  1  terminal count, combinational: 1 when q==MOD-1 and en=1.
- wrap  output  1  registered 1-cycle pulse, set on the edge where q moves from MOD-1 to 0 by counting.
- j_dbg  output  WIDTH  per-bit J inputs applied at the current edge (combinational).
- k_dbg  output  WIDTH  per-bit K inputs applied at the current edge (combinational).

Behaviour:
- Reset (reset=0, asynchronous): q=0, wrap=0. tc=0 while reset is asserted.
- Release of reset is sampled synchronously; the first count happens on the first clk edge with reset=1.
- Priority per edge: clr > load > en > hold.
- Target next value n:
  - clr: n=0.
  - load: n=din, or 0 if din>=MOD (out-of-range load clamps to 0).
  - en: n = (q==MOD-1) ? 0 : q+1.
  - else: n=q.
- JK excitation per bit i: J_i = ~q_i & n_i, K_i = q_i & ~n_i.
- JK characteristic: q_i <= (J_i & ~q_i) | (~K_i & q_i).
- j_dbg/k_dbg carry the J/K values above; in hold, all J=K=0.
- Latency: q reflects clr, load or en on the edge that samples them (1 cycle).
- wrap:
  - 1 for exactly the cycle after a counting transition MOD-1 -> 0.
  - Not set by clr or load, even when they produce 0.
  - Cleared on the next edge.
- Simultaneous events:
  - load+en: load wins, no increment, wrap=0.
  - clr+load: clr wins.
- Illegal state (q>=MOD, reachable only via a glitch or fault injection): the next en edge forces n=0, with no wrap pulse.
- Reset mid-count: q and wrap clear immediately, without waiting for a clk edge.
- MOD==2^WIDTH: natural binary wrap; the same rules apply.

Optional Feature:
- Macro: SYNC_UP_JK_SAT_EN.
- Defined:
  - At q==MOD-1 with en=1 the counter holds (n=q, J=K=0).
  - tc stays 1 while q==MOD-1 and en=1.
  - wrap is never asserted (tied to 0).
  - load and clr behave as normal.
- Undefined: modulo wrap-around as specified above.

Test Plan:
- Reset and count: assert reset=0 mid-count with q=7 -> q=0 and wrap=0 without a clk edge. Then release and hold en=1 for 12 edges (WIDTH=4, MOD=10) -> q runs 1..9,0,1,2; wrap=1 only in the cycle after 9->0; tc=1 while q=9.
- JK excitation: with q=0111 and en=1, check j_dbg=1000 and k_dbg=0111, then q=1000. With q=1001 and en=1 (MOD=10), check j_dbg=0000 and k_dbg=1001, then q=0000.
- Load: din=5 with load=1 -> q=5 next edge. din=12 with load=1 -> q=0. load=1 with en=1 at q=9 -> q=din and wrap=0.
- Clear priority: clr=1, load=1, en=1 with din=3 at q=6 -> q=0, wrap=0.
- Enable gating: en=0 for 5 edges at q=4 -> q stays 4; j_dbg=k_dbg=0; tc=0.
- Saturation (SYNC_UP_JK_SAT_EN defined): count from 0 with en=1 for 15 edges -> q stops at 9; wrap stays 0; tc stays 1 from the cycle q=9 onward.
